// File: rtl/execute_divider_pkg.sv
// Shared constants for the execute-stage divider: command encodings,
// controller state encoding and small command-decoding helpers.
package execute_divider_pkg;

    localparam logic [1:0] EXE_DIV_DIV  = 2'h0;
    localparam logic [1:0] EXE_DIV_UDIV = 2'h1;
    localparam logic [1:0] EXE_DIV_MOD  = 2'h2;
    localparam logic [1:0] EXE_DIV_UMOD = 2'h3;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        CALC = 2'h1,
        FIX  = 2'h2,
        OUT  = 2'h3
    } div_state_t;

    function automatic logic cmd_is_signed(input logic [1:0] cmd);
        return (cmd == EXE_DIV_DIV) || (cmd == EXE_DIV_MOD);
    endfunction

    function automatic logic cmd_is_mod(input logic [1:0] cmd);
        return (cmd == EXE_DIV_MOD) || (cmd == EXE_DIV_UMOD);
    endfunction

endpackage

// File: rtl/execute_divider_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module execute_divider_step #(
    parameter int P_N = 32
) (
    input  logic [P_N-1:0] rem,
    input  logic           dividend_bit,
    input  logic [P_N-1:0] divisor,
    output logic [P_N-1:0] next_rem,
    output logic           quo_bit
);

    logic [P_N:0] partial;
    logic [P_N:0] diff;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        partial  = {rem, dividend_bit};
        diff     = partial - {1'b0, divisor};
        quo_bit  = ~diff[P_N];
        next_rem = quo_bit ? diff[P_N-1:0] : partial[P_N-1:0];
    end

endmodule

// File: rtl/execute_divider.sv
// Multi-cycle signed/unsigned divider for the execute stage. One quotient
// bit per cycle on operand magnitudes, sign fix-up and flags in FIX,
// result held in OUT until the consumer takes it.
module execute_divider
    import execute_divider_pkg::*;
#(
    parameter int P_N = 32
) (
    input  logic           iCLOCK,
    input  logic           iRESET,
    input  logic           iFLUSH,
    input  logic           iREQ_VALID,
    output logic           oREQ_BUSY,
    input  logic [1:0]     iREQ_CMD,
    input  logic [P_N-1:0] iDATA_0,
    input  logic [P_N-1:0] iDATA_1,
    output logic           oOUT_VALID,
    input  logic           iOUT_BUSY,
    output logic [P_N-1:0] oDATA,
    output logic           oSF,
    output logic           oOF,
    output logic           oCF,
    output logic           oPF,
    output logic           oZF
);

    localparam int                CNT_W     = $clog2(P_N) + 1;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(P_N - 1);
    localparam logic [P_N-1:0]    MIN_NEG   = {1'b1, {(P_N-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic             accept;

    logic [1:0]       cmd_r;
    logic [P_N-1:0]   divisor_r;
    logic [P_N-1:0]   rem_r;
    logic [P_N-1:0]   quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             div_zero_r;
    logic             neg_quo_r;
    logic             neg_rem_r;
    logic             min_over_r;

    logic             req_signed;
    logic             req_zero;
    logic [P_N-1:0]   mag_0;
    logic [P_N-1:0]   mag_1;

    logic [P_N-1:0]   step_rem;
    logic             step_q;

    logic [P_N-1:0]   fix_data;
    logic             fix_cf;
    logic             fix_of;

    execute_divider_step #(
        .P_N(P_N)
    ) u_step (
        .rem          (rem_r),
        .dividend_bit (quo_r[P_N-1]),
        .divisor      (divisor_r),
        .next_rem     (step_rem),
        .quo_bit      (step_q)
    );

    // Controller state register.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides everything, including accept and OUT completion.
    always_comb begin
        state_next = state;
        if (iFLUSH) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (iREQ_VALID) state_next = CALC;
                // A zero divisor spends a single CALC cycle and goes straight to FIX.
                CALC: if (div_zero_r || (cnt_r == LAST_ITER)) state_next = FIX;
                FIX:  state_next = OUT;
                OUT:  if (!iOUT_BUSY) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        oREQ_BUSY  = (state != IDLE);
        oOUT_VALID = (state == OUT);
        accept     = iREQ_VALID && (state == IDLE) && !iFLUSH;
    end

    // Request decode: operand magnitudes for the iterative core.
    always_comb begin
        req_signed = cmd_is_signed(iREQ_CMD);
        req_zero   = (iDATA_1 == '0);
        mag_0      = (req_signed && iDATA_0[P_N-1]) ? -iDATA_0 : iDATA_0;
        mag_1      = (req_signed && iDATA_1[P_N-1]) ? -iDATA_1 : iDATA_1;
    end

    // Operand capture on accept, then one restoring step per CALC cycle.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            cmd_r      <= '0;
            divisor_r  <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            cnt_r      <= '0;
            div_zero_r <= 1'b0;
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            min_over_r <= 1'b0;
        end else if (accept) begin
            cmd_r      <= iREQ_CMD;
            divisor_r  <= mag_1;
            rem_r      <= '0;
            cnt_r      <= '0;
            // With a zero divisor no steps run, so the quotient register keeps
            // the raw dividend for the MOD/UMOD result.
            quo_r      <= req_zero ? iDATA_0 : mag_0;
            div_zero_r <= req_zero;
            neg_quo_r  <= req_signed && (iDATA_0[P_N-1] ^ iDATA_1[P_N-1]);
            neg_rem_r  <= req_signed && iDATA_0[P_N-1];
            min_over_r <= req_signed && (iDATA_0 == MIN_NEG) && (iDATA_1 == '1);
        end else if ((state == CALC) && !div_zero_r) begin
            rem_r <= step_rem;
            quo_r <= {quo_r[P_N-2:0], step_q};
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sign fix-up and special-case results for the FIX cycle.
    always_comb begin
        fix_data = '0;
        fix_cf   = 1'b0;
        fix_of   = 1'b0;
        if (div_zero_r) begin
            fix_data = cmd_is_mod(cmd_r) ? quo_r : '1;
            fix_cf   = 1'b1;
            fix_of   = 1'b1;
        end else if (cmd_is_mod(cmd_r)) begin
            fix_data = neg_rem_r ? -rem_r : rem_r;
        end else begin
            fix_data = neg_quo_r ? -quo_r : quo_r;
            fix_of   = min_over_r;
        end
    end

    // Result and flag registers, loaded in FIX and held through OUT.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oDATA <= '0;
            oSF   <= 1'b0;
            oOF   <= 1'b0;
            oCF   <= 1'b0;
            oPF   <= 1'b0;
            oZF   <= 1'b0;
        end else if ((state == FIX) && !iFLUSH) begin
            oDATA <= fix_data;
            oSF   <= fix_data[P_N-1];
            oOF   <= fix_of;
            oCF   <= fix_cf;
            oPF   <= fix_data[0];
            oZF   <= (fix_data == '0);
        end
    end

endmodule

// File: tb/tb_execute_divider.sv
// Randomized bench for execute_divider against an arithmetic reference model.
module tb_execute_divider;

    localparam int P_N = 32;
    localparam logic [1:0] C_DIV  = 2'h0;
    localparam logic [1:0] C_UDIV = 2'h1;
    localparam logic [1:0] C_MOD  = 2'h2;
    localparam logic [1:0] C_UMOD = 2'h3;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           flush     = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_busy;
    logic [1:0]     req_cmd   = 2'h0;
    logic [P_N-1:0] d0        = '0;
    logic [P_N-1:0] d1        = '0;
    logic           out_valid;
    logic           out_busy  = 1'b0;
    logic [P_N-1:0] data;
    logic           sf, of, cf, pf, zf;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    execute_divider #(.P_N(P_N)) dut (
        .iCLOCK     (clk),
        .iRESET     (rst),
        .iFLUSH     (flush),
        .iREQ_VALID (req_valid),
        .oREQ_BUSY  (req_busy),
        .iREQ_CMD   (req_cmd),
        .iDATA_0    (d0),
        .iDATA_1    (d1),
        .oOUT_VALID (out_valid),
        .iOUT_BUSY  (out_busy),
        .oDATA      (data),
        .oSF        (sf),
        .oOF        (of),
        .oCF        (cf),
        .oPF        (pf),
        .oZF        (zf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; flags as {SF, OF, CF, PF, ZF}.
    function automatic void ref_model(input logic [1:0] cmd, input logic [P_N-1:0] a,
                                      input logic [P_N-1:0] b, output logic [P_N-1:0] r,
                                      output logic [4:0] fl);
        int   sa;
        int   sb;
        logic ovf;
        logic car;
        logic min_case;
        sa       = $signed(a);
        sb       = $signed(b);
        ovf      = 1'b0;
        car      = 1'b0;
        r        = '0;
        min_case = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) begin
            r   = (cmd == C_MOD || cmd == C_UMOD) ? a : 32'hFFFF_FFFF;
            ovf = 1'b1;
            car = 1'b1;
        end else begin
            case (cmd)
                C_DIV:  if (min_case) begin r = a; ovf = 1'b1; end else r = sa / sb;
                C_MOD:  if (min_case) r = '0; else r = sa % sb;
                C_UDIV: r = a / b;
                default: r = a % b;
            endcase
        end
        fl = {r[P_N-1], ovf, car, r[0], (r == 0)};
    endfunction

    task automatic start_req(input logic [1:0] cmd, input logic [P_N-1:0] a, input logic [P_N-1:0] b);
        int unsigned k = 0;
        while (req_busy && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_before_req", req_busy, 0);
        req_cmd   = cmd;
        d0        = a;
        d1        = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_cmd   = 2'($urandom_range(0, 3));
        d0        = $urandom;
        d1        = $urandom;
        check("accepted", req_busy, 1);
    endtask

    task automatic watch_no_valid(input string tag, input int unsigned cycles);
        int unsigned seen = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic do_op(input logic [1:0] cmd, input logic [P_N-1:0] a, input logic [P_N-1:0] b,
                         input int unsigned hold, output logic [P_N-1:0] seen);
        logic [P_N-1:0] er;
        logic [4:0]     ef;
        int unsigned    k;
        ref_model(cmd, a, b, er, ef);
        out_busy = (hold != 0);
        start_req(cmd, a, b);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        // k counts edges after the accept edge; counting the accept edge as the
        // first, valid rises on edge P_N+2 (edge 3 for a zero divisor).
        check("latency", k, (b == 0) ? 2 : P_N + 1);
        seen = data;
        check("data", data, er);
        check("flags", {sf, of, cf, pf, zf}, ef);
        if (hold != 0) begin
            d0        = $urandom;
            d1        = $urandom;
            req_cmd   = 2'($urandom_range(0, 3));
            req_valid = 1'b1;
            for (int unsigned i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1);
                check("hold_data", data, er);
                check("hold_flags", {sf, of, cf, pf, zf}, ef);
            end
            req_valid = 1'b0;
            out_busy  = 1'b0;
        end
        @(posedge clk); #1;
        check("release_valid", out_valid, 0);
        check("release_idle", req_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [P_N-1:0] r;
        logic [1:0]     c;
        logic [P_N-1:0] a;
        logic [P_N-1:0] b;
        int unsigned    k;

        #2;
        check("reset_state", {req_busy, out_valid, data, sf, of, cf, pf, zf}, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(C_DIV, 32'd100, 32'd7, 0, r);
        check("div_100_7", r, 32'd14);
        do_op(C_MOD, 32'hFFFF_FFF9, 32'd2, 0, r);
        check("mod_m7_2", r, 32'hFFFF_FFFF);
        do_op(C_UMOD, 32'hFFFF_FFF9, 32'd2, 1, r);
        check("umod_m7_2", r, 32'd1);
        do_op(C_UDIV, 32'h1234_5678, 32'd0, 0, r);
        check("udiv_by_zero", r, 32'hFFFF_FFFF);
        do_op(C_UMOD, 32'h1234_5678, 32'd0, 0, r);
        check("umod_by_zero", r, 32'h1234_5678);
        do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, r);
        check("div_min_m1", r, 32'h8000_0000);
        do_op(C_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0, r);
        check("mod_min_m1", r, 32'd0);
        do_op(C_DIV, 32'hFFFF_FF9C, 32'd7, 5, r);
        check("div_m100_7_held", r, 32'hFFFF_FFF2);

        // Flush during CALC cycle 10.
        start_req(C_DIV, $urandom, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_idle", {req_busy, out_valid}, 2'b00);
        watch_no_valid("flush_calc_no_valid", 40);

        // Flush wins over a simultaneous request.
        flush     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_over_accept", req_busy, 0);

        // Flush while the result is held in OUT.
        out_busy = 1'b1;
        start_req(C_UDIV, 32'd50, 32'd5);
        k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        check("held_valid_reached", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        out_busy = 1'b0;
        check("flush_out_idle", {req_busy, out_valid}, 2'b00);

        // Asynchronous reset during CALC cycle 20.
        start_req(C_UDIV, $urandom, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1 check("reset_async", {req_busy, out_valid, data, sf, of, cf, pf, zf}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        watch_no_valid("reset_no_valid", 40);
        do_op(C_UDIV, 32'd9, 32'd3, 0, r);
        check("udiv_9_3", r, 32'd3);

        for (int n = 0; n < 60; n++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = $urandom >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(c, a, b, $urandom_range(0, 3), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
